// File: rtl/rr_req_gnt_mux.sv
// Requester side of a round-robin arbiter link: per-source FIFOs, gated request vector, registered output.
// Optional macro RR_REQ_GNT_ERR_EN adds err_sticky, a sticky flag for grants that break the one-hot protocol.
module rr_req_gnt_mux #(
    parameter int N     = 2,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*DW-1:0]      in_data,
    output logic [N-1:0]         req_out,
    input  logic [N-1:0]         gnt_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_src
`ifdef RR_REQ_GNT_ERR_EN
    ,
    output logic                 err_sticky
`endif
);

    localparam int SW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem    [N][DEPTH];
    logic [PW-1:0] wr_ptr [N];
    logic [PW-1:0] rd_ptr [N];
    logic [CW-1:0] count  [N];

    logic [N-1:0]  empty;
    logic [N-1:0]  full;
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic [N-1:0]  gq;
    logic          can_load;
    logic          load;
    logic [SW-1:0] sel;
    logic [DW-1:0] head;

    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < N; i++) begin
            empty[i] = (count[i] == '0);
            full[i]  = (count[i] == CW'(DEPTH));
        end
    end

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign can_load = !out_valid || out_ready;

    // Requests are withheld while the output is stalled so the arbiter pointer only moves on a real transfer.
    assign req_out  = ~empty & {N{can_load}};
    assign gq       = gnt_in & req_out;
    assign load     = can_load && (gq != '0);

    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (gq[i]) begin
                sel = SW'(i);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop[i] = load && (sel == SW'(i));
        end
    end

    assign head = mem[sel][rd_ptr[sel]];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= head;
            out_src   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RR_REQ_GNT_ERR_EN
    logic gq_onehot;
    logic gnt_stray;

    assign gq_onehot = (gq != '0) && ((gq & (gq - N'(1))) == '0);
    assign gnt_stray = ((gnt_in & ~req_out) != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (((req_out != '0) && !gq_onehot) || gnt_stray) begin
            err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_req_gnt_mux.sv
// Directed bench for rr_req_gnt_mux with a round-robin arbiter stand-in and a queue-based reference model.
module tb_rr_req_gnt_mux;

    localparam int N     = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    req_out;
    logic [N-1:0]    gnt_in;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [0:0]      out_src;
`ifdef RR_REQ_GNT_ERR_EN
    logic            err_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [0:0]   arb_ptr;
    logic         ovr_en;
    logic [N-1:0] ovr_val;

    logic [DW-1:0] log_d [$];
    int            log_s [$];
    int            log_c [$];
    logic [DW-1:0] exp_d [$];
    int            exp_s [$];

    rr_req_gnt_mux #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req_out   (req_out),
        .gnt_in    (gnt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
`ifdef RR_REQ_GNT_ERR_EN
        ,
        .err_sticky(err_sticky)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] g;
        g = '0;
        for (int o = 0; o < N; o++) begin
            int idx;
            idx = (p + o) % N;
            if (r[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // External arbiter stand-in: rotating priority, advancing past whoever was actually served.
    assign gnt_in = ovr_en ? ovr_val : rr_pick(req_out, int'(arb_ptr));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_ptr <= 1'b0;
        end else if ((gnt_in & req_out) != '0) begin
            arb_ptr <= 1'((lowest(gnt_in & req_out) + 1) % N);
        end
    end

    // Reference model: one queue per source plus the word currently presented downstream.
    logic [DW-1:0] mq [N][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    logic          m_err;
    logic          m_cl;
    logic [N-1:0]  m_req;
    logic [N-1:0]  m_rdy;
    logic [N-1:0]  m_g;
    logic [N-1:0]  m_gq;
    int            m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_err   = 1'b0;
        end else begin
            m_cl = !m_valid || out_ready;
            for (int i = 0; i < N; i++) begin
                m_req[i] = (mq[i].size() > 0) && m_cl;
                m_rdy[i] = (mq[i].size() < DEPTH);
            end
            m_g  = ovr_en ? ovr_val : rr_pick(m_req, int'(arb_ptr));
            m_gq = m_g & m_req;
            m_k  = lowest(m_gq);
            if ((m_req != '0) && ($countones(m_gq) != 1)) m_err = 1'b1;
            if ((m_g & ~m_req) != '0) m_err = 1'b1;
            if (m_k >= 0) begin
                m_data  = mq[m_k].pop_front();
                m_src   = m_k;
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && m_rdy[i]) mq[i].push_back(in_data[i*DW +: DW]);
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) begin
            log_d.push_back(out_data);
            log_s.push_back(int'(out_src));
            log_c.push_back(cyc);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every falling edge: DUT outputs against the reference model.
    always @(negedge clk) begin
        logic         cl;
        logic [N-1:0] er;
        logic [N-1:0] ei;
        cl = !m_valid || out_ready;
        for (int i = 0; i < N; i++) begin
            er[i] = (mq[i].size() > 0) && cl;
            ei[i] = (mq[i].size() < DEPTH);
        end
        checkOutput("model out_valid", 64'(out_valid), 64'(m_valid));
        checkOutput("model out_data",  64'(out_data),  64'(m_data));
        checkOutput("model out_src",   64'(out_src),   64'(m_src));
        checkOutput("model req_out",   64'(req_out),   64'(er));
        checkOutput("model in_ready",  64'(in_ready),  64'(ei));
`ifdef RR_REQ_GNT_ERR_EN
        checkOutput("model err_sticky", 64'(err_sticky), 64'(m_err));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [DW-1:0] d0,
                                 input logic [DW-1:0] d1, input logic ordy);
        in_valid  = v;
        in_data   = {d1, d0};
        out_ready = ordy;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ovr_en = 1'b0;
        ovr_val = '0;
        applyStimulus('0, '0, '0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        log_d.delete();
        log_s.delete();
        log_c.delete();
    endtask

    task automatic check_log(input string name, input logic check_back_to_back);
        checkOutput({name, " count"}, 64'(log_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < log_d.size(); i++) begin
            checkOutput({name, " data"}, 64'(log_d[i]), 64'(exp_d[i]));
            checkOutput({name, " src"},  64'(log_s[i]), 64'(exp_s[i]));
            if (check_back_to_back && i > 0)
                checkOutput({name, " gap"}, 64'(log_c[i] - log_c[i-1]), 64'd1);
        end
    endtask

    initial begin
        int  w;
        int  budget;
        logic ordy;
        logic fire;
        logic saw_full;

        do_reset();
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset in_ready",  64'(in_ready),  64'd3);
        checkOutput("reset req_out",   64'(req_out),   64'd0);

        // Single stream latency.
        applyStimulus(2'b01, 32'hA0, 32'h0, 1'b1);
        tick();
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
        checkOutput("single req c0", 64'(req_out), 64'd1);
        tick();
        checkOutput("single valid c1", 64'(out_valid), 64'd1);
        checkOutput("single data c1",  64'(out_data),  64'hA0);
        checkOutput("single src c1",   64'(out_src),   64'd0);
        tick();
        checkOutput("single valid c2", 64'(out_valid), 64'd0);

        // Fairness.
        do_reset();
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b1);
        tick();
        applyStimulus(2'b11, 32'h11, 32'h21, 1'b1);
        tick();
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (6) tick();
        exp_d = '{32'h10, 32'h20, 32'h11, 32'h21};
        exp_s = '{0, 1, 0, 1};
        check_log("fair", 1'b1);

        // Back-pressure with both FIFOs full.
        do_reset();
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b0);
        tick();
        applyStimulus(2'b11, 32'h11, 32'h21, 1'b0);
        tick();
        applyStimulus(2'b01, 32'h12, 32'h0, 1'b0);
        tick();
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall req_out",  64'(req_out),  64'd0);
            checkOutput("stall in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall out_data", 64'(out_data), 64'h10);
            checkOutput("stall valid",    64'(out_valid), 64'd1);
            tick();
        end
        checkOutput("stall arb ptr", 64'(arb_ptr), 64'd1);
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (8) tick();
        exp_d = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12};
        exp_s = '{0, 1, 0, 1, 0};
        check_log("backpressure", 1'b1);

        // Full and pointer wrap on source 1 with toggling out_ready.
        do_reset();
        w        = 1;
        ordy     = 1'b1;
        saw_full = 1'b0;
        budget   = 40;
        while (w <= 5 && budget > 0) begin
            applyStimulus(2'b10, 32'h0, DW'(w), ordy);
            fire = in_ready[1];
            if (!fire) saw_full = 1'b1;
            tick();
            if (fire) w++;
            ordy   = ~ordy;
            budget--;
        end
        checkOutput("wrap all pushed", 64'(w), 64'd6);
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (8) tick();
        checkOutput("wrap saw full", 64'(saw_full), 64'd1);
        exp_d = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        exp_s = '{1, 1, 1, 1, 1};
        check_log("wrap", 1'b0);

        // Reset mid-stream.
        do_reset();
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b0);
        tick();
        applyStimulus(2'b11, 32'h11, 32'h21, 1'b0);
        tick();
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("pre-reset valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst out_data",  64'(out_data),  64'd0);
        checkOutput("midrst req_out",   64'(req_out),   64'd0);
        checkOutput("midrst in_ready",  64'(in_ready),  64'd3);
        tick();
        rst = 1'b0;
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
        repeat (6) tick();
        checkOutput("postrst no words", 64'(log_d.size()), 64'd0);
        checkOutput("postrst valid",    64'(out_valid),    64'd0);

        // Double grant: lowest index wins.
        do_reset();
        applyStimulus(2'b11, 32'h10, 32'h20, 1'b1);
        tick();
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
        ovr_val = 2'b11;
        ovr_en  = 1'b1;
        checkOutput("dblgnt req_out", 64'(req_out), 64'd3);
        tick();
        ovr_en = 1'b0;
        checkOutput("dblgnt valid", 64'(out_valid), 64'd1);
        checkOutput("dblgnt src",   64'(out_src),   64'd0);
        checkOutput("dblgnt data",  64'(out_data),  64'h10);
`ifdef RR_REQ_GNT_ERR_EN
        checkOutput("err set", 64'(err_sticky), 64'd1);
        repeat (3) tick();
        checkOutput("err held", 64'(err_sticky), 64'd1);
`endif

        // Grant on a non-requesting source is ignored.
        do_reset();
`ifdef RR_REQ_GNT_ERR_EN
        checkOutput("err cleared", 64'(err_sticky), 64'd0);
`endif
        applyStimulus(2'b01, 32'h30, 32'h0, 1'b1);
        tick();
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1);
        ovr_val = 2'b10;
        ovr_en  = 1'b1;
        checkOutput("stray req_out", 64'(req_out), 64'd1);
        tick();
        ovr_en = 1'b0;
        checkOutput("stray no load", 64'(out_valid), 64'd0);
        tick();
        checkOutput("stray later valid", 64'(out_valid), 64'd1);
        checkOutput("stray later data",  64'(out_data),  64'h30);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_req_gnt_mux.md
Name: rr_req_gnt_mux

Overview:
- Requester-side companion to the team's round-robin arbiter. Owns the req/grant interface from the other end.
- Buffers N source streams in per-source FIFOs and drives a request vector to an external one-hot arbiter.
- Consumes the returned grant, pops the granted source and registers its word onto a single valid/ready output.
- Gates requests with output back-pressure, so the arbiter pointer only advances when a transfer really occurs.

Parameters:
- N, 2, number of sources; must be ≥2.
- DW, 32, payload width in bits.
- DEPTH, 2, entries per source FIFO; power of two, ≥2.

Ports:
- clk  input  1  clock; all logic is on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-source valid.
- in_ready  output  N  per-source ready; equals !full[i].
- in_data  input  N*DW  source i payload in bits [i*DW +: DW].
- req_out  output  N  request vector to the arbiter's req_in.
- gnt_in  input  N  one-hot grant from the arbiter; combinational from req_out.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DW  registered payload.
- out_src  output  clog2(N)  index of the source that produced out_data.

Behaviour:
- Reset (asynchronous, active-high) gives:
  - all FIFO pointers and counts 0; FIFO storage need not be cleared;
  - out_valid=0, out_data=0, out_src=0;
  - req_out=0 (follows from empty FIFOs); in_ready all 1.
- Reset asserted mid-operation discards all buffered and in-flight words. No partial transfer survives.
- Push: when in_valid[i] & in_ready[i], write in_data[i] into FIFO i. No bypass into the output register.
- can_load = !out_valid | out_ready.
- req_out[i] = !empty[i] & can_load. This is combinational, so no request reaches the arbiter while the output is stalled.
- Grant qualification:
  - gq = gnt_in & req_out;
  - if gq has more than one bit set, take the lowest index;
  - grant bits on non-requesting sources are ignored.
- Load: when can_load & |gq:
  - pop FIFO k (the qualified grant index);
  - out_data ← head[k], out_src ← k, out_valid ← 1.
- Drain: when out_valid & out_ready & no load, out_valid ← 0. out_data and out_src hold their last value.
- Throughput and latency:
  - one word per cycle sustained while out_ready=1 and any FIFO is non-empty;
  - minimum latency is 2 cycles: pushed at edge t, requested in cycle t, loaded at edge t+1, out_valid high from t+1.
- FIFO i boundaries:
  - push and pop in the same cycle are legal; count is unchanged;
  - when full, in_ready=0, so there is no simultaneous push while full;
  - pointers wrap modulo DEPTH;
  - count width is clog2(DEPTH)+1.
- Output stall: out_valid=1 & out_ready=0 holds out_data/out_src stable and forces req_out=0.
- Protocol obligation on the arbiter: gnt_in is a one-hot subset of req_out whenever |req_out, and zero otherwise.

Optional Feature:
- Macro RR_REQ_GNT_ERR_EN.
- When defined, adds port err_sticky (output, 1 bit, reset 0). It sets at a clock edge when |req_out and gq is not one-hot, or when gnt_in & ~req_out is non-zero. It stays set until rst.
- When undefined, the port and its logic are absent. Lowest-index selection and masking still apply.

Test Plan:
- Single stream, N=2, DEPTH=2, arbiter W=0:
  - stimulus: src0 pushes 0xA0 at cycle 0, out_ready=1;
  - required: req_out=2'b01 in cycle 0, out_valid=1 with out_data=0xA0 and out_src=0 at cycle 1, out_valid=0 at cycle 2.
- Fairness:
  - stimulus: both sources preloaded, src0 {0x10,0x11}, src1 {0x20,0x21}; out_ready=1;
  - required output order: 0x10, 0x20, 0x11, 0x21 on consecutive cycles, out_src alternating 0,1,0,1.
- Back-pressure:
  - stimulus: out_ready=0 for 5 cycles with both FIFOs full;
  - required: req_out=0 throughout, out_data constant, in_ready=2'b00, arbiter pointer unchanged; after release, order resumes exactly as in the fairness scenario.
- Full/wrap:
  - stimulus: src1 pushes 5 words 0x1..0x5 with out_ready toggling 1/0;
  - required: in_ready[1] drops when 2 words are buffered, all 5 emerge in order 0x1..0x5, no loss or duplication.
- Reset mid-stream:
  - stimulus: rst pulsed with 3 words buffered and out_valid=1;
  - required: immediately out_valid=0, out_data=0, req_out=0, in_ready=2'b11; no old word appears afterwards.
- Error (RR_REQ_GNT_ERR_EN defined):
  - stimulus: bench drives gnt_in=2'b11 while req_out=2'b11;
  - required: src0 is loaded, and err_sticky=1 from the next edge until rst.
